systolic_ws_ctrl: RTL

Sequencer for a ROW_NUM x COL_NUM weight-stationary systolic PE array. Each PE computes south <= north + weight*west and east <= west.
- Loads a weight tile row by row into a register bank that drives the array's weight inputs.
- Streams activation vectors into the west edge with per-row skew and drives the north edge with zero.
- Deskews the south-edge partial sums into aligned result vectors tagged valid/last.
- Sits between the tile DMA/feeder and the PE array.

---
 rtl/systolic_ws_pkg.sv | 21 ++
 rtl/systolic_ws_ctrl_if.sv | 35 +++
 rtl/systolic_skew_line.sv | 30 +++
 rtl/systolic_ws_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/systolic_ws_pkg.sv
// Shared types for the weight-stationary systolic array sequencer.
// Pipeline latency from activation accept to result is lat(ROW_NUM, COL_NUM) edges.
package systolic_ws_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN
   } state_t;

   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

   function automatic int lat(input int row_num, input int col_num);
      return row_num + col_num + 1;
   endfunction

endpackage

// File: rtl/systolic_ws_ctrl_if.sv
// Feeder, result sink and PE-array edge signals of the systolic sequencer.
// Weight/activation use valid-ready; results have no backpressure.
interface systolic_ws_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ROW_NUM    = 8,
   parameter int COL_NUM    = 8
) ();
   logic                                  w_valid;
   logic                                  w_ready;
   logic [COL_NUM*DATA_WIDTH-1:0]         w_data;
   logic                                  a_valid;
   logic                                  a_ready;
   logic [ROW_NUM*DATA_WIDTH-1:0]         a_data;
   logic                                  a_last;
   logic                                  res_valid;
   logic [COL_NUM*4*DATA_WIDTH-1:0]       res_data;
   logic                                  res_last;
   logic                                  busy;
   logic [ROW_NUM*DATA_WIDTH-1:0]         arr_wests;
   logic [COL_NUM*4*DATA_WIDTH-1:0]       arr_norths;
   logic [ROW_NUM*COL_NUM*DATA_WIDTH-1:0] arr_weights;
   logic [COL_NUM*4*DATA_WIDTH-1:0]       arr_souths;

   modport slave (
      input  w_valid, w_data, a_valid, a_data, a_last, arr_souths,
      output w_ready, a_ready, res_valid, res_data, res_last, busy,
             arr_wests, arr_norths, arr_weights
   );

   modport master (
      output w_valid, w_data, a_valid, a_data, a_last, arr_souths,
      input  w_ready, a_ready, res_valid, res_data, res_last, busy,
             arr_wests, arr_norths, arr_weights
   );
endinterface

// File: rtl/systolic_skew_line.sv
// Fixed-depth register delay line; DEPTH edges of latency, DEPTH=0 is a plain wire.
// No flow control: shifts every cycle.
module systolic_skew_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign q_o = d_i;
   end else begin : g_regs
      logic [WIDTH-1:0] pipe_q [DEPTH];

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
         end else begin
            pipe_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
         end
      end

      assign q_o = pipe_q[DEPTH-1];
   end
endmodule

// File: rtl/systolic_ws_ctrl.sv
// Weight-stationary array sequencer: loads weights, skews activations in, deskews results out.
// Result LAT=ROW_NUM+COL_NUM+1 edges after accept; one vector per cycle, sink cannot stall.
module systolic_ws_ctrl
   import systolic_ws_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ROW_NUM    = 8,
   parameter int COL_NUM    = 8
) (
   input  logic              clk,
   input  logic              reset,
   systolic_ws_ctrl_if.slave bus
);
   localparam int PW    = 4 * DATA_WIDTH;
   localparam int LAT   = lat(ROW_NUM, COL_NUM);
   localparam int ROW_W = $clog2(ROW_NUM + 1);
   localparam int DRN_W = $clog2(LAT + 1);
   localparam int WROW  = COL_NUM * DATA_WIDTH;

   state_t                        state_q;
   logic [ROW_W-1:0]              row_cnt_q;
   logic [DRN_W-1:0]              drain_cnt_q;
   logic                          w_loaded_q;
   logic [ROW_NUM*WROW-1:0]       wbank_q;
   logic                          a_fire;
   logic [ROW_NUM*DATA_WIDTH-1:0] a_q;
   logic [ROW_NUM*DATA_WIDTH-1:0] wests;
   tag_t                          tag_q;
   tag_t                          tag_out;
   logic [COL_NUM*PW-1:0]         souths_q;
   logic [COL_NUM*PW-1:0]         desk;
   logic [COL_NUM*PW-1:0]         res_data_q;

   assign a_fire = bus.a_valid && (state_q == STREAM);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         row_cnt_q   <= '0;
         drain_cnt_q <= '0;
         w_loaded_q  <= 1'b0;
         wbank_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               // A new weight tile always wins over a waiting batch.
               if (bus.w_valid) begin
                  state_q    <= LOAD_W;
                  w_loaded_q <= 1'b0;
               end else if (bus.a_valid && w_loaded_q) begin
                  state_q <= STREAM;
               end
            end
            LOAD_W: begin
               if (bus.w_valid) begin
                  wbank_q[int'(row_cnt_q)*WROW +: WROW] <= bus.w_data;
                  if (row_cnt_q == ROW_W'(ROW_NUM - 1)) begin
                     row_cnt_q  <= '0;
                     w_loaded_q <= 1'b1;
                     state_q    <= IDLE;
                  end else begin
                     row_cnt_q <= row_cnt_q + 1'b1;
                  end
               end
            end
            STREAM: begin
               if (a_fire && bus.a_last) begin
                  state_q     <= DRAIN;
                  drain_cnt_q <= DRN_W'(LAT);
               end
            end
            DRAIN: begin
               if (drain_cnt_q == '0) state_q <= IDLE;
               else                   drain_cnt_q <= drain_cnt_q - 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Non-accepting cycles push zero bubbles so the array never recomputes stale data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q        <= '0;
         tag_q      <= '0;
         souths_q   <= '0;
         res_data_q <= '0;
      end else begin
         a_q        <= a_fire ? bus.a_data : '0;
         tag_q      <= '{valid: a_fire, last: a_fire && bus.a_last};
         souths_q   <= bus.arr_souths;
         res_data_q <= desk;
      end
   end

   for (genvar i = 0; i < ROW_NUM; i++) begin : g_row
      systolic_skew_line #(.WIDTH(DATA_WIDTH), .DEPTH(i)) u_skew (
         .clk   (clk),
         .reset (reset),
         .d_i   (a_q[i*DATA_WIDTH +: DATA_WIDTH]),
         .q_o   (wests[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   for (genvar j = 0; j < COL_NUM; j++) begin : g_col
      systolic_skew_line #(.WIDTH(PW), .DEPTH(COL_NUM - 1 - j)) u_deskew (
         .clk   (clk),
         .reset (reset),
         .d_i   (souths_q[j*PW +: PW]),
         .q_o   (desk[j*PW +: PW])
      );
   end

   systolic_skew_line #(.WIDTH($bits(tag_t)), .DEPTH(LAT)) u_tag (
      .clk   (clk),
      .reset (reset),
      .d_i   (tag_q),
      .q_o   (tag_out)
   );

   assign bus.w_ready     = (state_q == LOAD_W);
   assign bus.a_ready     = (state_q == STREAM);
   assign bus.busy        = (state_q != IDLE);
   assign bus.res_valid   = tag_out.valid;
   assign bus.res_last    = tag_out.last;
   assign bus.res_data    = res_data_q;
   assign bus.arr_wests   = wests;
   assign bus.arr_norths  = '0;
   assign bus.arr_weights = wbank_q;
endmodule
